// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard/stall sequencer for the 5-stage core. It sits beside the forwarding unit
//   and handles the cases that forwarding cannot cover:
//   - load-use hazards get one bubble in ID/EX while PC and IF/ID hold;
//   - a taken branch squashes IF/ID and bubbles ID/EX;
//   - a data-memory access that is not ready freezes the pipe. Too long a freeze raises a
//     sticky mem_err and parks the core;
//   - a retired hlt parks the core in HALT until reset.
//   Control outputs are combinational from the state and the inputs (zero latency). They are
//   forced low while rst_n is low.
//
// Ports
//   clk, rst_n                      rising-edge clock, asynchronous active-low reset
//   p0_addr_ID/p1_addr_ID           source register addresses of the instruction in ID
//   re_p0_ID/re_p1_ID               instruction in ID actually reads that source
//   dst_addr_EX, re_mem_EX          destination of the instruction in EX, EX holds a load
//   branch_taken_EX                 branch/jump resolved taken in EX
//   mem_acc_MEM, mem_ready          MEM accesses data memory, memory completes this cycle
//   hlt_WB                          hlt instruction in WB
//   stall_PC .. flush_IF_ID         pipeline register hold/bubble/flush controls
//   halted                          core is in HALT
//   mem_err                         sticky memory-timeout flag
//   stall_cycles                    saturating count of cycles with stall_PC high

module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       p0_addr_ID,
    input  logic [3:0]       p1_addr_ID,
    input  logic             re_p0_ID,
    input  logic             re_p1_ID,
    input  logic [3:0]       dst_addr_EX,
    input  logic             re_mem_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_acc_MEM,
    input  logic             mem_ready,
    input  logic             hlt_WB,
    output logic             stall_PC,
    output logic             stall_IF_ID,
    output logic             bubble_ID_EX,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             bubble_MEM_WB,
    output logic             flush_IF_ID,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned   WaitW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [WaitW-1:0] wait_inc;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic lu;
    logic ms;
    logic p0_hit;
    logic p1_hit;

    // Raw controls before reset gating.
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic mem_wb_bubble;
    logic if_id_flush;
    logic halt_flag;

    // R0 is hardwired, so a load targeting it never creates a dependency.
    assign p0_hit = re_p0_ID && (p0_addr_ID == dst_addr_EX);
    assign p1_hit = re_p1_ID && (p1_addr_ID == dst_addr_EX);
    assign lu     = re_mem_EX && (dst_addr_EX != 4'd0) && (p0_hit || p1_hit);
    assign ms     = mem_acc_MEM && !mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        halt_flag     = 1'b0;

        // Count of consecutive frozen cycles including the current one.
        wait_inc = (state_q == StRun) ? WaitW'(1) : wait_cnt_q + WaitW'(1);

        unique case (state_q)
            StRun, StMemWait: begin
                if (ms) begin
                    // Full freeze; branch, LU and hlt stay put in their stages and are
                    // re-evaluated once memory releases the pipe.
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    id_ex_hold    = 1'b1;
                    ex_mem_hold   = 1'b1;
                    mem_wb_bubble = 1'b1;
                    if (wait_inc == TimeoutVal) begin
                        state_d    = StHalt;
                        mem_err_d  = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = StMemWait;
                        wait_cnt_d = wait_inc;
                    end
                end else begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                    if (branch_taken_EX) begin
                        // The ID instruction is wrong-path, so any LU on it is moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (lu) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                    // hlt has already retired, so it is honoured even beside a flush/bubble.
                    if (hlt_WB) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                pc_hold       = 1'b1;
                if_id_hold    = 1'b1;
                id_ex_hold    = 1'b1;
                ex_mem_hold   = 1'b1;
                mem_wb_bubble = 1'b1;
                halt_flag     = 1'b1;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_hold && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Gate with rst_n so the pipe sees no control while reset is held, regardless of inputs.
    assign stall_PC      = pc_hold && rst_n;
    assign stall_IF_ID   = if_id_hold && rst_n;
    assign bubble_ID_EX  = id_ex_bubble && rst_n;
    assign stall_ID_EX   = id_ex_hold && rst_n;
    assign stall_EX_MEM  = ex_mem_hold && rst_n;
    assign bubble_MEM_WB = mem_wb_bubble && rst_n;
    assign flush_IF_ID   = if_id_flush && rst_n;
    assign halted        = halt_flag && rst_n;
    assign mem_err       = mem_err_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MEM_TIMEOUT=15, CNT_W=5 so saturation is reachable).
// Inputs change just after the falling edge; outputs are sampled 2 ns later, well before the
// next rising edge.

module tb_hazard_stall_ctrl;

    localparam int unsigned CntW = 5;

    // Control vector order: stall_PC, stall_IF_ID, bubble_ID_EX, stall_ID_EX, stall_EX_MEM,
    // bubble_MEM_WB, flush_IF_ID, halted, mem_err.
    localparam logic [8:0] CtlNone   = 9'b000_000_000;
    localparam logic [8:0] CtlLu     = 9'b111_000_000;
    localparam logic [8:0] CtlBr     = 9'b001_000_100;
    localparam logic [8:0] CtlFrz    = 9'b110_111_000;
    localparam logic [8:0] CtlHalt   = 9'b110_111_010;
    localparam logic [8:0] CtlHaltEr = 9'b110_111_011;

    logic            clk;
    logic            rst_n;
    logic [3:0]      p0_addr_ID;
    logic [3:0]      p1_addr_ID;
    logic            re_p0_ID;
    logic            re_p1_ID;
    logic [3:0]      dst_addr_EX;
    logic            re_mem_EX;
    logic            branch_taken_EX;
    logic            mem_acc_MEM;
    logic            mem_ready;
    logic            hlt_WB;
    logic            stall_PC;
    logic            stall_IF_ID;
    logic            bubble_ID_EX;
    logic            stall_ID_EX;
    logic            stall_EX_MEM;
    logic            bubble_MEM_WB;
    logic            flush_IF_ID;
    logic            halted;
    logic            mem_err;
    logic [CntW-1:0] stall_cycles;

    logic [8:0] ctl;
    int         errors;
    int         checks;

    assign ctl = {stall_PC, stall_IF_ID, bubble_ID_EX, stall_ID_EX, stall_EX_MEM,
                  bubble_MEM_WB, flush_IF_ID, halted, mem_err};

    hazard_stall_ctrl #(
        .MEM_TIMEOUT(15),
        .CNT_W      (CntW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p0_addr_ID     (p0_addr_ID),
        .p1_addr_ID     (p1_addr_ID),
        .re_p0_ID       (re_p0_ID),
        .re_p1_ID       (re_p1_ID),
        .dst_addr_EX    (dst_addr_EX),
        .re_mem_EX      (re_mem_EX),
        .branch_taken_EX(branch_taken_EX),
        .mem_acc_MEM    (mem_acc_MEM),
        .mem_ready      (mem_ready),
        .hlt_WB         (hlt_WB),
        .stall_PC       (stall_PC),
        .stall_IF_ID    (stall_IF_ID),
        .bubble_ID_EX   (bubble_ID_EX),
        .stall_ID_EX    (stall_ID_EX),
        .stall_EX_MEM   (stall_EX_MEM),
        .bubble_MEM_WB  (bubble_MEM_WB),
        .flush_IF_ID    (flush_IF_ID),
        .halted         (halted),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_ctl(input string tag, input logic [8:0] exp);
        checks++;
        assert (ctl === exp) else begin
            errors++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CntW-1:0] exp);
        checks++;
        assert (stall_cycles === exp) else begin
            errors++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_addr_ID      = 4'd0;
        p1_addr_ID      = 4'd0;
        re_p0_ID        = 1'b0;
        re_p1_ID        = 1'b0;
        dst_addr_EX     = 4'd0;
        re_mem_EX       = 1'b0;
        branch_taken_EX = 1'b0;
        mem_acc_MEM     = 1'b0;
        mem_ready       = 1'b0;
        hlt_WB          = 1'b0;
    endtask

    // Advance to just after the next falling edge.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        idle_inputs();
        #1 rst_n = 1'b0;

        // Reset: a pending memory stall and a load-use pattern must not leak out.
        mem_acc_MEM = 1'b1;
        re_mem_EX   = 1'b1;
        dst_addr_EX = 4'd3;
        re_p0_ID    = 1'b1;
        p0_addr_ID  = 4'd3;
        settle();
        chk_ctl("reset_outputs", CtlNone);
        chk_cnt("reset_count", 5'd0);
        next_cyc();
        idle_inputs();
        rst_n = 1'b1;
        settle();
        chk_ctl("run_idle", CtlNone);

        // 1) Load-use on p0: exactly one stall cycle.
        next_cyc();
        re_mem_EX   = 1'b1;
        dst_addr_EX = 4'd3;
        re_p0_ID    = 1'b1;
        p0_addr_ID  = 4'd3;
        settle();
        chk_ctl("lu_p0", CtlLu);
        next_cyc();
        idle_inputs();
        settle();
        chk_ctl("lu_after", CtlNone);
        chk_cnt("lu_count", 5'd1);

        // 2) R0 destination never hazards; an unread matching source never hazards.
        next_cyc();
        re_mem_EX   = 1'b1;
        dst_addr_EX = 4'd0;
        re_p0_ID    = 1'b1;
        p0_addr_ID  = 4'd0;
        settle();
        chk_ctl("lu_r0", CtlNone);
        next_cyc();
        idle_inputs();
        re_mem_EX   = 1'b1;
        dst_addr_EX = 4'd5;
        re_p1_ID    = 1'b0;
        p1_addr_ID  = 4'd5;
        settle();
        chk_ctl("lu_p1_unread", CtlNone);
        next_cyc();
        re_p1_ID = 1'b1;
        settle();
        chk_ctl("lu_p1_read", CtlLu);
        next_cyc();
        idle_inputs();
        settle();
        chk_cnt("lu_p1_count", 5'd2);

        // 3) Branch and load-use together: flush wins, PC not held.
        next_cyc();
        branch_taken_EX = 1'b1;
        re_mem_EX       = 1'b1;
        dst_addr_EX     = 4'd7;
        re_p0_ID        = 1'b1;
        p0_addr_ID      = 4'd7;
        settle();
        chk_ctl("br_lu", CtlBr);
        next_cyc();
        idle_inputs();
        settle();
        chk_ctl("br_after", CtlNone);
        chk_cnt("br_count", 5'd2);

        // 4) Three-cycle memory wait with a branch waiting in EX and hlt_WB on one freeze
        //    cycle; freeze wins, branch fires on release, hlt is not latched.
        next_cyc();
        mem_acc_MEM     = 1'b1;
        mem_ready       = 1'b0;
        branch_taken_EX = 1'b1;
        settle();
        chk_ctl("mw_frz1", CtlFrz);
        next_cyc();
        settle();
        chk_ctl("mw_frz2", CtlFrz);
        next_cyc();
        hlt_WB = 1'b1;
        settle();
        chk_ctl("mw_frz3_hlt", CtlFrz);
        next_cyc();
        hlt_WB    = 1'b0;
        mem_ready = 1'b1;
        settle();
        chk_ctl("mw_release_br", CtlBr);
        next_cyc();
        idle_inputs();
        settle();
        chk_ctl("mw_after", CtlNone);
        chk_cnt("mw_count", 5'd5);

        // 5) Timeout: 15 frozen cycles, then HALT with mem_err; counter saturates.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        next_cyc();
        mem_acc_MEM = 1'b1;
        mem_ready   = 1'b0;
        for (int i = 0; i < 15; i++) begin
            settle();
            chk_ctl($sformatf("to_frz%0d", i + 1), CtlFrz);
            next_cyc();
        end
        settle();
        chk_ctl("to_halt", CtlHaltEr);
        chk_cnt("to_count", 5'd15);
        idle_inputs();
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cyc();
        end
        settle();
        chk_ctl("to_sticky", CtlHaltEr);
        chk_cnt("to_saturate", 5'd31);

        // 6) hlt_WB -> HALT next cycle; async reset mid-HALT clears everything at once.
        #1 rst_n = 1'b0;
        #1;
        chk_ctl("to_reset", CtlNone);
        chk_cnt("to_reset_count", 5'd0);
        rst_n = 1'b1;
        next_cyc();
        idle_inputs();
        hlt_WB = 1'b1;
        settle();
        chk_ctl("hlt_cycle", CtlNone);
        next_cyc();
        hlt_WB = 1'b0;
        settle();
        chk_ctl("hlt_halted", CtlHalt);
        chk_cnt("hlt_count0", 5'd0);
        next_cyc();
        settle();
        chk_ctl("hlt_held", CtlHalt);
        chk_cnt("hlt_count1", 5'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_ctl("hlt_async_reset", CtlNone);
        chk_cnt("hlt_reset_count", 5'd0);
        rst_n = 1'b1;
        next_cyc();
        settle();
        chk_ctl("post_reset_run", CtlNone);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
